base_agate_sched: RTL

- Round-robin burst scheduler that drives the per-lane `en` vector of a `base_agate` array.
- N requesters share one downstream sink. At most one lane is enabled at a time.
- The grant is held for a configurable number of handshake beats, or until the granted requester drops valid. It then rotates.
- Sits beside the gate array: observes its valids and readies and produces its enables.

---
 rtl/base_agate_sched_if.sv | 16 +
 rtl/base_agate_sched.sv | 125 ++++++++++++
 2 files changed

// File: rtl/base_agate_sched_if.sv
// Lane-side bundle between the burst scheduler and a base_agate gate array:
// requester valids and downstream readies in, gate enables and grant status out.
interface base_agate_sched_if #(
  parameter int ways = 4
);
  localparam int iw = (ways > 1) ? $clog2(ways) : 1;

  logic [0:ways-1] i_v;
  logic [0:ways-1] o_r;
  logic [0:ways-1] en;
  logic [0:iw-1]   gnt_idx;
  logic            busy;

  modport master (input i_v, o_r, output en, gnt_idx, busy);
  modport slave  (output i_v, o_r, input en, gnt_idx, busy);
endinterface

// File: rtl/base_agate_sched.sv
// Round-robin burst scheduler: grants one lane at a time for a latched number
// of beats (or until the lane drops valid), then rotates without a bubble.
module base_agate_sched #(
  parameter int ways   = 4,
  parameter int bwidth = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:bwidth-1] cfg_burst,
  input  logic              hold,
  base_agate_sched_if.master bus
);
  localparam int iw = (ways > 1) ? $clog2(ways) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [0:ways-1]   en_q, en_d;
  logic [0:iw-1]     gnt_q, gnt_d;
  logic [0:iw-1]     ptr_q, ptr_d;
  logic [0:bwidth-1] cnt_q, cnt_d;
  logic [0:bwidth-1] lim_q, lim_d;

  logic              win_found;
  logic [0:iw-1]     win_idx;
  logic [0:iw-1]     arb_ptr;
  logic              beat;
  logic              last_beat;
  logic              release_g;

  // On release the just-finished lane becomes the rotation pointer, so it is
  // searched last and re-wins only when nobody else is asking.
  assign arb_ptr = (state_q == GRANT) ? gnt_q : ptr_q;

  // NOTE: every variable driven here gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    logic [0:iw-1] slot;
    win_found = 1'b0;
    win_idx   = '0;
    slot      = '0;
    for (int k = 1; k <= ways; k++) begin
      slot = iw'((int'(arb_ptr) + k) % ways);
      if (!win_found && !hold && bus.i_v[slot]) begin
        win_found = 1'b1;
        win_idx   = slot;
      end
    end
  end

  assign beat      = (state_q == GRANT) && bus.i_v[gnt_q] && bus.o_r[gnt_q];
  assign last_beat = beat && (lim_q != '0) && (cnt_q == lim_q - bwidth'(1));
  assign release_g = (state_q == GRANT) && (last_beat || !bus.i_v[gnt_q]);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;

    // Saturating count: only reachable with an unlimited burst, where the
    // value is never compared.
    if (beat && (cnt_q != {bwidth{1'b1}})) begin
      cnt_d = cnt_q + bwidth'(1);
    end

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d        = GRANT;
          en_d           = '0;
          en_d[win_idx]  = 1'b1;
          gnt_d          = win_idx;
          cnt_d          = '0;
          lim_d          = cfg_burst;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_d = gnt_q;
          if (win_found) begin
            en_d          = '0;
            en_d[win_idx] = 1'b1;
            gnt_d         = win_idx;
            cnt_d         = '0;
            lim_d         = cfg_burst;
          end else begin
            state_d = IDLE;
            en_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= '0;
      gnt_q   <= '0;
      ptr_q   <= iw'(ways - 1);
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  assign bus.en      = en_q;
  assign bus.gnt_idx = gnt_q;
  assign bus.busy    = (state_q == GRANT);
endmodule
